// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// regfile_pkg : shared register-file sizing constants and helpers
// Revision    : 1.0
// ---------------------------------------------------------------------
package regfile_pkg;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_DEPTH  = 32;
   localparam int DEFAULT_ADDR_W = 5;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   // One extra bit so a full scoreboard (every register busy) is representable.
   function automatic int busy_cnt_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
      cnt_op_e op;
      op = CNT_HOLD;
      if (inc && !dec) begin
         op = CNT_INC;
      end else if (dec && !inc) begin
         op = CNT_DEC;
      end
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------
// regfile_scoreboard : per-register busy bits and running busy count
// Revision           : 1.0
// ---------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1,
   localparam int CNT_W   = busy_cnt_w(ADDR_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_valid_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_valid_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [ADDR_W-1:0] query_a_i,
   input  logic [ADDR_W-1:0] query_b_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic [CNT_W-1:0]  busy_count_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             w_set_en;
   logic             w_clr_en;
   logic             w_inc;
   logic             w_dec;
   cnt_op_e          w_op;

   always_comb begin
      w_set_en = set_valid_i && !((ZERO_REG != 0) && (set_addr_i == '0));
      w_clr_en = clr_valid_i && !((ZERO_REG != 0) && (clr_addr_i == '0));

      // A clear and a set on the same register leave it busy, so that clear
      // must not be counted as a release.
      w_inc = w_set_en && !busy_q[set_addr_i];
      w_dec = w_clr_en && busy_q[clr_addr_i] &&
              !(w_set_en && (set_addr_i == clr_addr_i));
      w_op  = cnt_op(w_inc, w_dec);

      busy_d = busy_q;
      if (w_clr_en) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (w_set_en) begin
         busy_d[set_addr_i] = 1'b1;
      end

      count_d = count_q;
      case (w_op)
         CNT_INC: count_d = count_q + CNT_W'(1);
         CNT_DEC: count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_a_o     = busy_q[query_a_i];
   assign busy_b_o     = busy_q[query_b_i];
   assign busy_count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ---------------------------------------------------------------------
// regfile_sb : 2R/1W register file with write bypass and busy scoreboard
// Revision   : 1.0
// ---------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [ADDR_W-1:0] rd,
   input  logic [WIDTH-1:0]  busW,
   input  logic              writeEnable,
   input  logic              issueValid,
   input  logic [ADDR_W-1:0] issueRd,
   output logic [WIDTH-1:0]  busA,
   output logic [WIDTH-1:0]  busB,
   output logic              busyA,
   output logic              busyB,
   output logic [ADDR_W:0]   busyCount
);

   if ((DEPTH != (1 << ADDR_W)) || (DEPTH < 2) || (DEPTH > 64)) begin : g_depth_check
      $error("regfile_sb: DEPTH must be 2**ADDR_W and within 2..64");
   end

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             w_wr_en;
   logic             w_byp_a;
   logic             w_byp_b;
   logic             w_zero_a;
   logic             w_zero_b;

   assign w_wr_en = writeEnable && !((ZERO_REG != 0) && (rd == '0));

   always_comb begin
      regs_d = regs_q;
      if (w_wr_en) begin
         regs_d[rd] = busW;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Forwarding is suppressed while reset is asserted since that write is discarded.
   always_comb begin
      w_byp_a  = (BYPASS != 0) && reset && w_wr_en && (ra == rd);
      w_byp_b  = (BYPASS != 0) && reset && w_wr_en && (rb == rd);
      w_zero_a = (ZERO_REG != 0) && (ra == '0);
      w_zero_b = (ZERO_REG != 0) && (rb == '0);

      busA = regs_q[ra];
      if (w_zero_a) begin
         busA = '0;
      end else if (w_byp_a) begin
         busA = busW;
      end

      busB = regs_q[rb];
      if (w_zero_b) begin
         busB = '0;
      end else if (w_byp_b) begin
         busB = busW;
      end
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .set_valid_i  (issueValid),
      .set_addr_i   (issueRd),
      .clr_valid_i  (writeEnable),
      .clr_addr_i   (rd),
      .query_a_i    (ra),
      .query_b_i    (rb),
      .busy_a_o     (busyA),
      .busy_b_o     (busyB),
      .busy_count_o (busyCount)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------
// tb_regfile_sb : directed and randomized checks against a behavioural model
// Revision      : 1.0
// ---------------------------------------------------------------------
module tb_regfile_sb;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = 5;
   localparam int CW = AW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ra, rb, rd, issueRd;
   logic [W-1:0]  busW;
   logic          writeEnable, issueValid;
   logic [W-1:0]  busA, busB;
   logic          busyA, busyB;
   logic [AW:0]   busyCount;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] m_mem  [D];
   bit           m_busy [D];

   always #5 clk = ~clk;

   regfile_sb #(
      .WIDTH    (W),
      .DEPTH    (D),
      .ADDR_W   (AW),
      .ZERO_REG (1),
      .BYPASS   (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ra          (ra),
      .rb          (rb),
      .rd          (rd),
      .busW        (busW),
      .writeEnable (writeEnable),
      .issueValid  (issueValid),
      .issueRd     (issueRd),
      .busA        (busA),
      .busB        (busB),
      .busyA       (busyA),
      .busyB       (busyB),
      .busyCount   (busyCount)
   );

   function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (reset && writeEnable && (a == rd)) return busW;
      return m_mem[a];
   endfunction

   function automatic logic m_busy_of(input logic [AW-1:0] a);
      return (a == '0) ? 1'b0 : 1'(m_busy[a]);
   endfunction

   function automatic logic [AW:0] m_count();
      int n;
      n = 0;
      for (int i = 1; i < D; i++) n += int'(m_busy[i]);
      return CW'(n);
   endfunction

   task automatic idle();
      writeEnable = 1'b0;
      issueValid  = 1'b0;
      rd          = '0;
      issueRd     = '0;
      busW        = '0;
   endtask

   // One rising edge; the model absorbs the same inputs the DUT sampled.
   task automatic cycle();
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (writeEnable && (rd != '0)) begin
            m_mem[rd]  = busW;
            m_busy[rd] = 1'b0;
         end
         if (issueValid && (issueRd != '0)) m_busy[issueRd] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      ra = '0;
      rb = '0;
      cycle();
      ra = 5'd3;
      rb = 5'd15;
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL reset_busA: got %h expected %h", busA, 32'h0); end
      checks++; if (busB !== 32'h0) begin errors++; $display("FAIL reset_busB: got %h expected %h", busB, 32'h0); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busyA: got %b expected 0", busyA); end
      checks++; if (busyB !== 1'b0) begin errors++; $display("FAIL reset_busyB: got %b expected 0", busyB); end
      checks++; if (busyCount !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", busyCount); end
      writeEnable = 1'b1;
      rd          = 5'd3;
      busW        = 32'hAAAA5555;
      issueValid  = 1'b1;
      issueRd     = 5'd3;
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL reset_no_bypass: got %h expected %h", busA, 32'h0); end
      cycle();
      idle();
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL reset_write_ignored: got %h expected %h", busA, 32'h0); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_issue_ignored: got %b expected 0", busyA); end
      reset = 1'b1;
   endtask

   task automatic test_bypass();
      idle();
      rd          = 5'd3;
      busW        = 32'h01010101;
      writeEnable = 1'b1;
      ra          = 5'd3;
      #1;
      checks++; if (busA !== 32'h01010101) begin errors++; $display("FAIL bypass_before_edge: got %h expected %h", busA, 32'h01010101); end
      checks++; if (busA !== m_read(ra)) begin errors++; $display("FAIL bypass_model: got %h expected %h", busA, m_read(ra)); end
      cycle();
      idle();
      #1;
      checks++; if (busA !== 32'h01010101) begin errors++; $display("FAIL write_after_edge: got %h expected %h", busA, 32'h01010101); end
   endtask

   task automatic test_scoreboard();
      idle();
      issueValid = 1'b1;
      issueRd    = 5'd15;
      cycle();
      idle();
      rb = 5'd15;
      #1;
      checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL issue_busyB: got %b expected 1", busyB); end
      checks++; if (busyCount !== 6'd1) begin errors++; $display("FAIL issue_count: got %0d expected 1", busyCount); end
      writeEnable = 1'b1;
      rd          = 5'd15;
      busW        = 32'd9;
      #1;
      checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL busy_no_bypass: got %b expected 1", busyB); end
      checks++; if (busB !== 32'd9) begin errors++; $display("FAIL bypass_busB: got %h expected %h", busB, 32'd9); end
      cycle();
      idle();
      #1;
      checks++; if (busB !== 32'd9) begin errors++; $display("FAIL write_busB: got %h expected %h", busB, 32'd9); end
      checks++; if (busyB !== 1'b0) begin errors++; $display("FAIL write_clears_busy: got %b expected 0", busyB); end
      checks++; if (busyCount !== 6'd0) begin errors++; $display("FAIL write_count: got %0d expected 0", busyCount); end
   endtask

   task automatic test_same_and_diff_reg();
      idle();
      issueValid = 1'b1;
      issueRd    = 5'd7;
      cycle();
      issueValid  = 1'b1;
      issueRd     = 5'd7;
      writeEnable = 1'b1;
      rd          = 5'd7;
      busW        = 32'd5;
      cycle();
      idle();
      ra = 5'd7;
      #1;
      checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL same_reg_busy: got %b expected 1", busyA); end
      checks++; if (busyCount !== 6'd1) begin errors++; $display("FAIL same_reg_count: got %0d expected 1", busyCount); end
      checks++; if (busA !== 32'd5) begin errors++; $display("FAIL same_reg_data: got %h expected %h", busA, 32'd5); end
      // Issue 9 while writing 7: both take effect in the same edge.
      issueValid  = 1'b1;
      issueRd     = 5'd9;
      writeEnable = 1'b1;
      rd          = 5'd7;
      busW        = 32'd77;
      cycle();
      idle();
      ra = 5'd7;
      rb = 5'd9;
      #1;
      checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL diff_reg_clear: got %b expected 0", busyA); end
      checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL diff_reg_set: got %b expected 1", busyB); end
      checks++; if (busyCount !== 6'd1) begin errors++; $display("FAIL diff_reg_count: got %0d expected 1", busyCount); end
      // Re-issue of a busy register and a write to an idle one leave the count alone.
      issueValid  = 1'b1;
      issueRd     = 5'd9;
      writeEnable = 1'b1;
      rd          = 5'd20;
      busW        = 32'h12345678;
      cycle();
      idle();
      ra = 5'd20;
      #1;
      checks++; if (busyCount !== 6'd1) begin errors++; $display("FAIL reissue_count: got %0d expected 1", busyCount); end
      checks++; if (busA !== 32'h12345678) begin errors++; $display("FAIL nonbusy_write: got %h expected %h", busA, 32'h12345678); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL nonbusy_stays: got %b expected 0", busyA); end
   endtask

   task automatic test_zero_reg();
      logic [AW:0] cnt_before;
      idle();
      cnt_before  = m_count();
      writeEnable = 1'b1;
      rd          = '0;
      busW        = 32'hFFFFFFFF;
      issueValid  = 1'b1;
      issueRd     = '0;
      ra          = '0;
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL zero_no_bypass: got %h expected %h", busA, 32'h0); end
      cycle();
      idle();
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL zero_read: got %h expected %h", busA, 32'h0); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busyA); end
      checks++; if (busyCount !== cnt_before) begin errors++; $display("FAIL zero_count: got %0d expected %0d", busyCount, cnt_before); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset       = ($urandom_range(0, 39) != 0);
         ra          = AW'($urandom_range(0, D - 1));
         rb          = AW'($urandom_range(0, D - 1));
         rd          = AW'($urandom_range(0, D - 1));
         issueRd     = AW'($urandom_range(0, D - 1));
         busW        = $urandom;
         writeEnable = 1'($urandom_range(0, 1));
         issueValid  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) issueRd = rd;
         if ($urandom_range(0, 3) == 0) ra = rd;
         if ($urandom_range(0, 5) == 0) rb = rd;
         #1;
         checks++; if (busA !== m_read(ra)) begin errors++; $display("FAIL rand_busA[%0d] ra=%0d: got %h expected %h", n, ra, busA, m_read(ra)); end
         checks++; if (busB !== m_read(rb)) begin errors++; $display("FAIL rand_busB[%0d] rb=%0d: got %h expected %h", n, rb, busB, m_read(rb)); end
         checks++; if (busyA !== m_busy_of(ra)) begin errors++; $display("FAIL rand_busyA[%0d] ra=%0d: got %b expected %b", n, ra, busyA, m_busy_of(ra)); end
         checks++; if (busyB !== m_busy_of(rb)) begin errors++; $display("FAIL rand_busyB[%0d] rb=%0d: got %b expected %b", n, rb, busyB, m_busy_of(rb)); end
         checks++; if (busyCount !== m_count()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, busyCount, m_count()); end
         cycle();
      end
      reset = 1'b1;
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      writeEnable = 1'b1;
      rd          = 5'd3;
      busW        = 32'hDEADBEEF;
      cycle();
      idle();
      for (int r = 1; r < D; r++) begin
         issueValid = 1'b1;
         issueRd    = AW'(r);
         cycle();
      end
      idle();
      #1;
      checks++; if (busyCount !== 6'd31) begin errors++; $display("FAIL full_count: got %0d expected 31", busyCount); end
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      #1;
      checks++; if (busyCount !== 6'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", busyCount); end
      for (int r = 0; r < D; r++) begin
         ra = AW'(r);
         #1;
         checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL mid_reset_busy[%0d]: got %b expected 0", r, busyA); end
      end
      ra = 5'd3;
      #1;
      checks++; if (busA !== 32'h0) begin errors++; $display("FAIL mid_reset_reg3: got %h expected %h", busA, 32'h0); end
   endtask

   initial begin
      for (int i = 0; i < D; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      reset = 1'b0;
      ra    = '0;
      rb    = '0;
      idle();
      #1;
      test_reset();
      test_bypass();
      test_scoreboard();
      test_same_and_diff_reg();
      test_zero_reg();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, number of registers (power of two, 2..64).
REQ-003 Parameter ADDR_W, default 5, register address bits, equals log2(DEPTH).
REQ-004 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, never busy.
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle write data forwarded to read buses.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-008 ra  input  ADDR_W  read port A register number.
REQ-009 rb  input  ADDR_W  read port B register number.
REQ-010 rd  input  ADDR_W  write register number.
REQ-011 busW  input  WIDTH  write data.
REQ-012 writeEnable  input  1  1 = write busW into rd at clk edge, clears busy[rd].
REQ-013 issueValid  input  1  1 = mark issueRd busy (pending writer issued) at clk edge.
REQ-014 issueRd  input  ADDR_W  register to mark busy.
REQ-015 busA  output  WIDTH  value of register ra.
REQ-016 busB  output  WIDTH  value of register rb.
REQ-017 busyA  output  1  busy bit of ra.
REQ-018 busyB  output  1  busy bit of rb.
REQ-019 busyCount  output  ADDR_W+1  number of registers currently busy.

Function
REQ-020 Reads combinational, zero latency: busA/busB reflect the register array and any bypass in the same cycle.
REQ-021 Write: writeEnable=1 at a rising edge stores busW in rd; value visible on reads from the next cycle.
REQ-022 BYPASS=1: writeEnable=1 and ra==rd (rb==rd) drives busA (busB) = busW combinationally; BYPASS=0: old value until the edge.
REQ-023 ZERO_REG=1: reads of register 0 return 0; writes to 0 ignored; issue to 0 ignored; busy[0] stays 0; bypass never applies to register 0.
REQ-024 Scoreboard: busy[issueRd] set to 1 on edge with issueValid=1; busy[rd] cleared on edge with writeEnable=1.
REQ-025 Simultaneous issue and write, same register: busy ends 1 (issue wins, new writer pending); data still written.
REQ-026 Simultaneous issue and write, different registers: both take effect in the same edge.
REQ-027 Issue to an already busy register: busy stays 1, busyCount unchanged.
REQ-028 Write to a non-busy register: legal, data stored, busy stays 0, busyCount unchanged.
REQ-029 busyA/busyB report the registered busy bit; a write in the current cycle does not clear them combinationally (no bypass on busy).
REQ-030 busyCount is registered, updated each edge by +1/-1/0 per REQ-024..028; never exceeds DEPTH (DEPTH-1 when ZERO_REG=1).
REQ-031 Addresses >= DEPTH cannot occur (DEPTH = 2^ADDR_W enforced at elaboration).

Reset
REQ-032 reset=0 at an edge clears all registers to 0, all busy bits to 0, busyCount to 0; writes and issues in that cycle ignored.
REQ-033 During reset busA/busB show array contents (0 after first reset edge); bypass disabled while reset=0.
REQ-034 Reset mid-operation discards all pending busy state; no recovery of outstanding writers.

Structure
REQ-035 Package regfile_pkg holds default WIDTH/DEPTH/ADDR_W constants and the busy-count width function; shared with datapath.
REQ-036 Sub-module regfile_scoreboard holds busy bits and busyCount; regfile_sb instantiates it plus the data array and bypass muxing.

Verification
REQ-037 Reset=0 one edge, then ra=3, rb=15 -> busA=0, busB=0, busyA=busyB=0, busyCount=0.
REQ-038 rd=3, busW=32'h01010101, writeEnable=1, ra=3 same cycle -> busA=01010101 before edge (BYPASS=1); BYPASS=0 build shows 0 until edge, 01010101 after.
REQ-039 Issue rd=15; next cycle rb=15 -> busyB=1, busyCount=1; write rd=15 busW=9 -> after edge busB=9, busyB=0, busyCount=0.
REQ-040 Same edge issueRd=7 and write rd=7 busW=5 while busy[7]=1 -> busy[7]=1, busyCount unchanged, reg7=5.
REQ-041 Write rd=0 busW=FFFFFFFF and issue 0 -> busA(ra=0)=0, busyA=0, busyCount=0.
REQ-042 Issue regs 1..31, then reset=0 one edge -> busyCount=0, all busy=0, reg 3 reads 0.
